fb_rd_line_sched: RTL and testbench
===================================

# fb_rd_line_sched

Line-read scheduler for the frame-buffer read path. It sits between the video timing source and the DDR read engine. On each frame sync it selects the frame buffer to display and computes its base address. It then issues one DDR read request per active line, paced by line-buffer credits returned from the pixel re-concatenation stage downstream.

## Interface
- C_ADDR_W, 32, DDR byte-address width
- C_LEN_W, 24, read length width (bytes)
- C_LINE_CREDITS, 2, number of line buffers downstream (1..7)
- CLK_I  in  1  single clock for all logic
- RST_I  in  1  reset, synchronous, active-high
- PIXEL_VS_I  in  1  frame sync; a rising edge starts a frame
- CFG_BASE_ADDR_I  in  C_ADDR_W  address of frame buffer 0
- CFG_FRAME_SIZE_I  in  C_ADDR_W  byte distance between consecutive frame buffers
- CFG_LINE_STRIDE_I  in  C_ADDR_W  byte distance between lines
- CFG_H_ACTIVE_I  in  16  pixels per line
- CFG_V_ACTIVE_I  in  16  lines per frame
- ACTUAL_DDR_BYTE_NUM_I  in  8  bytes per packed pixel in DDR
- WR_FRAME_IDX_I  in  2  index of the last frame fully written (0..2)
- RD_REQ_O  out  1  read request
- RD_ADDR_O  out  C_ADDR_W  line start address
- RD_LEN_O  out  C_LEN_W  line length in bytes
- RD_ACK_I  in  1  request accepted
- RD_DONE_I  in  1  pulse: all data for the current request delivered
- LINE_CONSUMED_I  in  1  pulse: downstream freed one line buffer
- RD_FRAME_IDX_O  out  2  frame buffer being read
- FRAME_DONE_O  out  1  one-cycle pulse when the last line completes
- FRAME_ERR_O  out  1  one-cycle pulse when a frame is aborted by an early VS
- CFG_ERR_O  out  1  sticky; set when the line length overflows C_LEN_W

## Operation
- **VS edge detect:** PIXEL_VS_I is registered once; a rising edge is prev=0, cur=1.
- **States:** IDLE, FRAME_START, WAIT_CREDIT, REQ, WAIT_DONE.
- **IDLE:**
  - On a VS edge, go to FRAME_START.
  - Set pending_vs if the edge occurs in any state other than IDLE or FRAME_START.
- **FRAME_START** (one cycle):
  - Latch all CFG_* inputs and ACTUAL_DDR_BYTE_NUM_I; latch RD_FRAME_IDX_O = WR_FRAME_IDX_I.
  - If the latched index is 3, treat it as 0.
  - frame_base = CFG_BASE_ADDR_I + idx*CFG_FRAME_SIZE_I; line_addr = frame_base.
  - line_cnt = 0; credits = C_LINE_CREDITS; clear pending_vs.
  - If H or V is 0: pulse FRAME_DONE_O and go to IDLE. Otherwise go to WAIT_CREDIT.
- **Line length:** line_len = H_ACTIVE*BYTE_NUM, computed as a full 24-bit product.
  - If the product does not fit C_LEN_W, truncate it and set CFG_ERR_O.
  - CFG_ERR_O clears only on RST_I.
- **WAIT_CREDIT:**
  - If pending_vs is set: pulse FRAME_ERR_O and go to FRAME_START.
  - Else if credits>0, go to REQ.
- **REQ:**
  - RD_REQ_O=1. RD_ADDR_O=line_addr and RD_LEN_O=line_len, both held stable until RD_ACK_I.
  - On ack: credits decrements and the state goes to WAIT_DONE.
- **WAIT_DONE:**
  - On RD_DONE_I: line_cnt+1 and line_addr += stride.
  - If line_cnt+1 == V_ACTIVE: pulse FRAME_DONE_O and go to IDLE.
  - Else if pending_vs is set: pulse FRAME_ERR_O and go to FRAME_START.
  - Else go to WAIT_CREDIT.
- **Credits:**
  - Increment on LINE_CONSUMED_I and saturate at C_LINE_CREDITS.
  - Ack and consume in the same cycle leaves credits unchanged.
- **Early VS:** an in-flight request is never abandoned. Both REQ and WAIT_DONE finish their handshake before an abort takes effect.
- **Address arithmetic:** wraps modulo 2^C_ADDR_W.

## Timing
- **Reset values:** state=IDLE, credits=C_LINE_CREDITS, and every output is 0.
- **Reset mid-frame:** RST_I wins over all other inputs in the same cycle.
- **Frame start:** a VS edge is sampled high at cycle n. FRAME_START occurs at n+1. WAIT_CREDIT occurs at n+2. RD_REQ_O is first high at n+3.
- **Request/ack:** RD_REQ_O falls in the cycle after RD_ACK_I is sampled high. An ack in the first REQ cycle gives a 1-cycle request.
- **Next line:** after RD_DONE_I is sampled, the next RD_REQ_O rises 2 cycles later if credit is available.
- **Frame end:** FRAME_DONE_O is high in the cycle after the final RD_DONE_I.
- **VS at frame end:** a VS edge in that same cycle is accepted normally from IDLE.

## Test plan
- **Basic frame:** H=1920, BYTE_NUM=5, V=4, base=0x1000_0000, stride=0x2800, WR_FRAME_IDX=1, FRAME_SIZE=0x100_0000, ack immediate, consume after each done.
  - Expect 4 requests, each with len 9600.
  - Expect addresses 0x1100_0000, 0x1100_2800, 0x1100_5000, 0x1100_7800.
  - Expect FRAME_DONE_O once.
- **Credit stall:** C_LINE_CREDITS=2, V=4, no LINE_CONSUMED_I.
  - Expect exactly 2 requests, then the block holds in WAIT_CREDIT.
  - One consume pulse releases exactly 1 more request.
- **Early VS:** VS edge while in WAIT_DONE of line 1.
  - RD_DONE_I still completes line 1.
  - Then FRAME_ERR_O pulses and a new frame restarts at frame_base with line_cnt=0.
- **Overflow and zero size:**
  - H=65535, BYTE_NUM=255, C_LEN_W=16: expect RD_LEN_O = the truncated product and CFG_ERR_O sticky at 1.
  - V=0: expect FRAME_DONE_O at n+2 and no request.
- **Handshake hold:** hold RD_ACK_I low for 10 cycles.
  - Expect RD_REQ_O, RD_ADDR_O and RD_LEN_O stable throughout.
  - Simultaneous ack+consume leaves credits unchanged.
- **Reset mid-operation:** assert RST_I during REQ.
  - Next cycle: RD_REQ_O=0, state=IDLE, credits=C_LINE_CREDITS.

Source files
------------

// File: rtl/fb_rd_line_sched.sv
// Line-read scheduler for the frame-buffer read path.
// Picks the frame buffer on each VS rising edge, then issues one DDR read
// per active line, paced by line-buffer credits from the downstream stage.
module fb_rd_line_sched #(
    parameter int C_ADDR_W       = 32,
    parameter int C_LEN_W        = 24,
    parameter int C_LINE_CREDITS = 2
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                PIXEL_VS_I,
    input  logic [C_ADDR_W-1:0] CFG_BASE_ADDR_I,
    input  logic [C_ADDR_W-1:0] CFG_FRAME_SIZE_I,
    input  logic [C_ADDR_W-1:0] CFG_LINE_STRIDE_I,
    input  logic [15:0]         CFG_H_ACTIVE_I,
    input  logic [15:0]         CFG_V_ACTIVE_I,
    input  logic [7:0]          ACTUAL_DDR_BYTE_NUM_I,
    input  logic [1:0]          WR_FRAME_IDX_I,
    output logic                RD_REQ_O,
    output logic [C_ADDR_W-1:0] RD_ADDR_O,
    output logic [C_LEN_W-1:0]  RD_LEN_O,
    input  logic                RD_ACK_I,
    input  logic                RD_DONE_I,
    input  logic                LINE_CONSUMED_I,
    output logic [1:0]          RD_FRAME_IDX_O,
    output logic                FRAME_DONE_O,
    output logic                FRAME_ERR_O,
    output logic                CFG_ERR_O
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_START,
        S_WAIT_CREDIT,
        S_REQ,
        S_WAIT_DONE
    } state_t;

    // Credit counter is 3 bits: up to 7 downstream line buffers.
    localparam logic [2:0] CRED_MAX = 3'(C_LINE_CREDITS);

    state_t                state_q, state_d;
    logic                  vs_q;
    logic                  pend_q, pend_d;
    logic [2:0]            cred_q, cred_d;
    logic [15:0]           line_cnt_q, line_cnt_d;
    logic [15:0]           v_active_q, v_active_d;
    logic [C_ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [C_ADDR_W-1:0]   stride_q, stride_d;
    logic [C_LEN_W-1:0]    len_q, len_d;
    logic [1:0]            idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  vs_edge;
    logic                  ack;
    logic [15:0]           line_cnt_inc;
    logic [C_ADDR_W-1:0]   frame_base;
    logic [23:0]           prod;
    logic [C_LEN_W+23:0]   prod_ext;

    assign vs_edge      = PIXEL_VS_I & ~vs_q;
    assign ack          = (state_q == S_REQ) & RD_ACK_I;
    assign line_cnt_inc = line_cnt_q + 16'd1;

    // Full 24-bit product; anything above C_LEN_W is an overflow.
    assign prod     = 24'(CFG_H_ACTIVE_I) * 24'(ACTUAL_DDR_BYTE_NUM_I);
    assign prod_ext = {{C_LEN_W{1'b0}}, prod};

    // Frame base: index 3 is not a valid buffer and falls back to buffer 0.
    always_comb begin
        case (WR_FRAME_IDX_I)
            2'd1:    frame_base = CFG_BASE_ADDR_I + CFG_FRAME_SIZE_I;
            2'd2:    frame_base = CFG_BASE_ADDR_I + {CFG_FRAME_SIZE_I[C_ADDR_W-2:0], 1'b0};
            default: frame_base = CFG_BASE_ADDR_I;
        endcase
    end

    // Next-state, credit accounting and output pulse generation.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cred_d      = cred_q;
        line_cnt_d  = line_cnt_q;
        v_active_d  = v_active_q;
        line_addr_d = line_addr_q;
        stride_d    = stride_q;
        len_d       = len_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cfg_err_d   = cfg_err_q;

        // A VS edge mid-frame is remembered and acted on once the
        // current handshake has finished.
        if (vs_edge && (state_q == S_WAIT_CREDIT || state_q == S_REQ ||
                        state_q == S_WAIT_DONE))
            pend_d = 1'b1;

        // Simultaneous ack and consume cancel out.
        if (LINE_CONSUMED_I && !ack) begin
            if (cred_q != CRED_MAX)
                cred_d = cred_q + 3'd1;
        end else if (ack && !LINE_CONSUMED_I) begin
            cred_d = cred_q - 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (vs_edge)
                    state_d = S_FRAME_START;
            end
            S_FRAME_START: begin
                idx_d       = (WR_FRAME_IDX_I == 2'd3) ? 2'd0 : WR_FRAME_IDX_I;
                line_addr_d = frame_base;
                stride_d    = CFG_LINE_STRIDE_I;
                v_active_d  = CFG_V_ACTIVE_I;
                len_d       = prod_ext[C_LEN_W-1:0];
                if (|prod_ext[C_LEN_W+23:C_LEN_W])
                    cfg_err_d = 1'b1;
                line_cnt_d  = 16'd0;
                cred_d      = CRED_MAX;
                pend_d      = 1'b0;
                if (CFG_H_ACTIVE_I == 16'd0 || CFG_V_ACTIVE_I == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_CREDIT;
                end
            end
            S_WAIT_CREDIT: begin
                if (pend_q) begin
                    err_d   = 1'b1;
                    state_d = S_FRAME_START;
                end else if (cred_q != 3'd0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (RD_ACK_I)
                    state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (RD_DONE_I) begin
                    line_cnt_d  = line_cnt_inc;
                    line_addr_d = line_addr_q + stride_q;
                    if (line_cnt_inc == v_active_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (pend_q) begin
                        err_d   = 1'b1;
                        state_d = S_FRAME_START;
                    end else begin
                        state_d = S_WAIT_CREDIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset overrides everything else in the same cycle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b0;
            pend_q      <= 1'b0;
            cred_q      <= CRED_MAX;
            line_cnt_q  <= 16'd0;
            v_active_q  <= 16'd0;
            line_addr_q <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            idx_q       <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= PIXEL_VS_I;
            pend_q      <= pend_d;
            cred_q      <= cred_d;
            line_cnt_q  <= line_cnt_d;
            v_active_q  <= v_active_d;
            line_addr_q <= line_addr_d;
            stride_q    <= stride_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign RD_REQ_O       = (state_q == S_REQ);
    assign RD_ADDR_O      = line_addr_q;
    assign RD_LEN_O       = len_q;
    assign RD_FRAME_IDX_O = idx_q;
    assign FRAME_DONE_O   = done_q;
    assign FRAME_ERR_O    = err_q;
    assign CFG_ERR_O      = cfg_err_q;

endmodule

// File: tb/tb_fb_rd_line_sched.sv
// Bench for fb_rd_line_sched: directed scenarios with literal expectations,
// then randomized traffic, all continuously compared against a behavioural
// model of the scheduler.
module tb_fb_rd_line_sched;

    localparam int AW = 32;
    localparam int LW = 16;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          RST_I, PIXEL_VS_I, RD_ACK_I, RD_DONE_I, LINE_CONSUMED_I;
    logic [AW-1:0] CFG_BASE_ADDR_I, CFG_FRAME_SIZE_I, CFG_LINE_STRIDE_I;
    logic [15:0]   CFG_H_ACTIVE_I, CFG_V_ACTIVE_I;
    logic [7:0]    ACTUAL_DDR_BYTE_NUM_I;
    logic [1:0]    WR_FRAME_IDX_I;
    logic          RD_REQ_O, FRAME_DONE_O, FRAME_ERR_O, CFG_ERR_O;
    logic [AW-1:0] RD_ADDR_O;
    logic [LW-1:0] RD_LEN_O;
    logic [1:0]    RD_FRAME_IDX_O;

    always #5 clk = ~clk;

    fb_rd_line_sched #(.C_ADDR_W(AW), .C_LEN_W(LW), .C_LINE_CREDITS(NC)) dut (
        .CLK_I(clk), .RST_I(RST_I), .PIXEL_VS_I(PIXEL_VS_I),
        .CFG_BASE_ADDR_I(CFG_BASE_ADDR_I), .CFG_FRAME_SIZE_I(CFG_FRAME_SIZE_I),
        .CFG_LINE_STRIDE_I(CFG_LINE_STRIDE_I), .CFG_H_ACTIVE_I(CFG_H_ACTIVE_I),
        .CFG_V_ACTIVE_I(CFG_V_ACTIVE_I), .ACTUAL_DDR_BYTE_NUM_I(ACTUAL_DDR_BYTE_NUM_I),
        .WR_FRAME_IDX_I(WR_FRAME_IDX_I), .RD_REQ_O(RD_REQ_O), .RD_ADDR_O(RD_ADDR_O),
        .RD_LEN_O(RD_LEN_O), .RD_ACK_I(RD_ACK_I), .RD_DONE_I(RD_DONE_I),
        .LINE_CONSUMED_I(LINE_CONSUMED_I), .RD_FRAME_IDX_O(RD_FRAME_IDX_O),
        .FRAME_DONE_O(FRAME_DONE_O), .FRAME_ERR_O(FRAME_ERR_O), .CFG_ERR_O(CFG_ERR_O)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 frame start, 2 wait credit, 3 request, 4 wait done.
    bit          m_on = 1'b0;
    int          m_ph, m_line, m_cred, m_v, m_idx, m_len;
    bit          m_vsp, m_pend, m_done, m_err, m_cfgerr;
    logic [31:0] m_base, m_stride;

    // observed traffic, used by directed checks
    logic [31:0] acc_addr[$];
    int          acc_len[$];
    int          n_done = 0;
    int          n_err  = 0;

    task automatic model_step();
        bit     edge_s, ack, pend_old;
        int     cred_old;
        longint p;
        if (RST_I) begin
            m_on = 1'b1; m_ph = 0; m_cred = NC; m_pend = 0; m_done = 0; m_err = 0;
            m_cfgerr = 0; m_idx = 0; m_base = '0; m_stride = '0; m_line = 0;
            m_len = 0; m_v = 0; m_vsp = 0;
            return;
        end
        edge_s   = PIXEL_VS_I && !m_vsp;
        m_vsp    = PIXEL_VS_I;
        ack      = (m_ph == 3) && RD_ACK_I;
        pend_old = m_pend;
        cred_old = m_cred;
        m_done   = 0;
        m_err    = 0;
        if (edge_s && m_ph >= 2) m_pend = 1;
        if (LINE_CONSUMED_I && !ack) m_cred = (m_cred + 1 > NC) ? NC : m_cred + 1;
        else if (ack && !LINE_CONSUMED_I) m_cred = m_cred - 1;
        case (m_ph)
            0: if (edge_s) m_ph = 1;
            1: begin
                m_idx    = (WR_FRAME_IDX_I == 2'd3) ? 0 : int'(WR_FRAME_IDX_I);
                m_base   = CFG_BASE_ADDR_I + 32'(m_idx) * CFG_FRAME_SIZE_I;
                m_stride = CFG_LINE_STRIDE_I;
                m_v      = int'(CFG_V_ACTIVE_I);
                m_line   = 0;
                m_cred   = NC;
                m_pend   = 0;
                p        = longint'(CFG_H_ACTIVE_I) * longint'(ACTUAL_DDR_BYTE_NUM_I);
                m_len    = int'(p % (64'd1 << LW));
                if (p >= (64'd1 << LW)) m_cfgerr = 1;
                if (CFG_H_ACTIVE_I == 0 || CFG_V_ACTIVE_I == 0) begin
                    m_done = 1; m_ph = 0;
                end else m_ph = 2;
            end
            2: if (pend_old) begin m_err = 1; m_ph = 1; end
               else if (cred_old > 0) m_ph = 3;
            3: if (RD_ACK_I) m_ph = 4;
            4: if (RD_DONE_I) begin
                m_line++;
                if (m_line == m_v) begin m_done = 1; m_ph = 0; end
                else if (pend_old) begin m_err = 1; m_ph = 1; end
                else m_ph = 2;
            end
            default: m_ph = 0;
        endcase
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with
    // the inputs the DUT will sample at the next rising edge.
    always @(negedge clk) begin
        logic [31:0] exp_addr;
        if (m_on) begin
            chk("req", 64'(RD_REQ_O), 64'(m_ph == 3));
            if (m_ph == 3) begin
                exp_addr = m_base + 32'(m_line) * m_stride;
                chk("addr", 64'(RD_ADDR_O), 64'(exp_addr));
                chk("len", 64'(RD_LEN_O), 64'(m_len));
            end
            chk("frame_idx", 64'(RD_FRAME_IDX_O), 64'(m_idx));
            chk("frame_done", 64'(FRAME_DONE_O), 64'(m_done));
            chk("frame_err", 64'(FRAME_ERR_O), 64'(m_err));
            chk("cfg_err", 64'(CFG_ERR_O), 64'(m_cfgerr));
            if (RD_REQ_O && RD_ACK_I) begin
                acc_addr.push_back(RD_ADDR_O);
                acc_len.push_back(int'(RD_LEN_O));
            end
            if (FRAME_DONE_O) n_done++;
            if (FRAME_ERR_O) n_err++;
        end
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        while (!RD_REQ_O && k < budget) begin
            tick();
            k++;
        end
        chk("wait_req", 64'(RD_REQ_O), 64'd1);
    endtask

    task automatic vs_edge();
        PIXEL_VS_I = 1'b1;
        tick();
        PIXEL_VS_I = 1'b0;
    endtask

    task automatic do_line();
        wait_req(50);
        RD_ACK_I = 1'b1; tick(); RD_ACK_I = 1'b0;
        tick();
        RD_DONE_I = 1'b1; tick(); RD_DONE_I = 1'b0;
        LINE_CONSUMED_I = 1'b1; tick(); LINE_CONSUMED_I = 1'b0;
    endtask

    task automatic do_reset();
        RST_I = 1'b1; tick(); tick(); RST_I = 1'b0;
    endtask

    task automatic clr_obs();
        acc_addr.delete();
        acc_len.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    logic [31:0] exp_a[4];

    initial begin
        exp_a = '{32'h1100_0000, 32'h1100_2800, 32'h1100_5000, 32'h1100_7800};
        RST_I = 1'b1; PIXEL_VS_I = 0; RD_ACK_I = 0; RD_DONE_I = 0; LINE_CONSUMED_I = 0;
        CFG_BASE_ADDR_I = 32'h1000_0000; CFG_FRAME_SIZE_I = 32'h0100_0000;
        CFG_LINE_STRIDE_I = 32'h2800; CFG_H_ACTIVE_I = 16'd1920; CFG_V_ACTIVE_I = 16'd4;
        ACTUAL_DDR_BYTE_NUM_I = 8'd5; WR_FRAME_IDX_I = 2'd1;
        repeat (3) tick();
        RST_I = 1'b0;

        // reset state
        chk("rst_req", 64'(RD_REQ_O), 64'd0);
        chk("rst_addr", 64'(RD_ADDR_O), 64'd0);
        chk("rst_len", 64'(RD_LEN_O), 64'd0);
        chk("rst_idx", 64'(RD_FRAME_IDX_O), 64'd0);
        chk("rst_cfgerr", 64'(CFG_ERR_O), 64'd0);

        // basic frame with frame-start latency
        clr_obs();
        PIXEL_VS_I = 1'b1; tick(); PIXEL_VS_I = 1'b0;
        chk("lat_n1", 64'(RD_REQ_O), 64'd0);
        tick();
        chk("lat_n2", 64'(RD_REQ_O), 64'd0);
        tick();
        chk("lat_n3", 64'(RD_REQ_O), 64'd1);
        repeat (4) do_line();
        repeat (5) tick();
        chk("basic_nreq", 64'(acc_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            chk("basic_addr", 64'(acc_addr[i]), 64'(exp_a[i]));
            chk("basic_len", 64'(acc_len[i]), 64'd9600);
        end
        chk("basic_ndone", 64'(n_done), 64'd1);
        chk("basic_idx", 64'(RD_FRAME_IDX_O), 64'd1);

        // credit stall: no consumes
        clr_obs();
        RD_ACK_I = 1'b1; RD_DONE_I = 1'b1;
        vs_edge();
        repeat (20) tick();
        chk("stall_nreq", 64'(acc_addr.size()), 64'd2);
        LINE_CONSUMED_I = 1'b1; tick(); LINE_CONSUMED_I = 1'b0;
        repeat (20) tick();
        chk("stall_release", 64'(acc_addr.size()), 64'd3);
        LINE_CONSUMED_I = 1'b1; tick(); LINE_CONSUMED_I = 1'b0;
        repeat (20) tick();
        chk("stall_final", 64'(acc_addr.size()), 64'd4);
        chk("stall_ndone", 64'(n_done), 64'd1);
        RD_ACK_I = 1'b0; RD_DONE_I = 1'b0;

        // early VS while line 1 is in flight
        clr_obs();
        vs_edge();
        do_line();
        wait_req(20);
        RD_ACK_I = 1'b1; tick(); RD_ACK_I = 1'b0;
        vs_edge();
        tick();
        RD_DONE_I = 1'b1; tick(); RD_DONE_I = 1'b0;
        wait_req(20);
        chk("early_nreq", 64'(acc_addr.size()), 64'd2);
        chk("early_nerr", 64'(n_err), 64'd1);
        chk("early_restart_addr", 64'(RD_ADDR_O), 64'h1100_0000);

        // handshake hold, then ack+consume together
        clr_obs();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_req", 64'(RD_REQ_O), 64'd1);
            chk("hold_addr", 64'(RD_ADDR_O), 64'h1100_0000);
            chk("hold_len", 64'(RD_LEN_O), 64'd9600);
        end
        RD_ACK_I = 1'b1; LINE_CONSUMED_I = 1'b1; tick(); LINE_CONSUMED_I = 1'b0;
        RD_DONE_I = 1'b1;
        repeat (20) tick();
        chk("ackcons_nreq", 64'(acc_addr.size()), 64'd3);
        RD_ACK_I = 1'b0; RD_DONE_I = 1'b0;

        // reset during REQ
        LINE_CONSUMED_I = 1'b1; tick(); LINE_CONSUMED_I = 1'b0;
        wait_req(10);
        RST_I = 1'b1; tick(); RST_I = 1'b0;
        chk("rstmid_req", 64'(RD_REQ_O), 64'd0);
        chk("rstmid_addr", 64'(RD_ADDR_O), 64'd0);
        chk("rstmid_idx", 64'(RD_FRAME_IDX_O), 64'd0);
        clr_obs();
        RD_ACK_I = 1'b1; RD_DONE_I = 1'b1;
        vs_edge();
        repeat (20) tick();
        chk("rstmid_credits", 64'(acc_addr.size()), 64'd2);
        RD_ACK_I = 1'b0; RD_DONE_I = 1'b0;
        do_reset();

        // length overflow, sticky error
        CFG_H_ACTIVE_I = 16'hFFFF; ACTUAL_DDR_BYTE_NUM_I = 8'd255; CFG_V_ACTIVE_I = 16'd1;
        WR_FRAME_IDX_I = 2'd3;
        vs_edge();
        wait_req(10);
        chk("ovf_len", 64'(RD_LEN_O), 64'hFF01);
        chk("ovf_cfgerr", 64'(CFG_ERR_O), 64'd1);
        chk("ovf_idx3", 64'(RD_FRAME_IDX_O), 64'd0);
        chk("ovf_addr", 64'(RD_ADDR_O), 64'h1000_0000);
        do_line();
        repeat (3) tick();

        // zero-line frame
        clr_obs();
        CFG_H_ACTIVE_I = 16'd100; ACTUAL_DDR_BYTE_NUM_I = 8'd2; CFG_V_ACTIVE_I = 16'd0;
        PIXEL_VS_I = 1'b1; tick(); PIXEL_VS_I = 1'b0;
        chk("v0_done_n1", 64'(FRAME_DONE_O), 64'd0);
        tick();
        chk("v0_done_n2", 64'(FRAME_DONE_O), 64'd1);
        repeat (5) tick();
        chk("v0_nreq", 64'(acc_addr.size()), 64'd0);
        chk("cfgerr_sticky", 64'(CFG_ERR_O), 64'd1);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) PIXEL_VS_I = ~PIXEL_VS_I;
            if ($urandom_range(0, 24) == 0) begin
                CFG_BASE_ADDR_I       = $urandom;
                CFG_FRAME_SIZE_I      = $urandom;
                CFG_LINE_STRIDE_I     = $urandom;
                CFG_H_ACTIVE_I        = ($urandom_range(0, 3) == 0) ? 16'hFFFF
                                        : 16'($urandom_range(0, 2000));
                CFG_V_ACTIVE_I        = 16'($urandom_range(0, 5));
                ACTUAL_DDR_BYTE_NUM_I = 8'($urandom_range(0, 255));
                WR_FRAME_IDX_I        = 2'($urandom_range(0, 3));
            end
            RD_ACK_I        = ($urandom_range(0, 1) == 0);
            RD_DONE_I       = ($urandom_range(0, 2) == 0);
            LINE_CONSUMED_I = ($urandom_range(0, 2) == 0);
            RST_I           = ($urandom_range(0, 399) == 0);
            tick();
        end
        RST_I = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
